phase_sequencer: RTL and testbench

Programmable phase sequencer that steps a WIDTH-bit phase index from 0 to a captured terminal value, in single-shot or continuous mode. It sits directly upstream of the 3:8 decoder stage. `phase` drives the decoder select input and `phase_valid` drives the decoder enable. An optional registered one-hot copy of the phase lets timing-critical consumers bypass the decoder.

---
 rtl/phase_sequencer.sv | 171 +++++++++++++++++
 tb/tb_phase_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// ============================================================================
// phase_sequencer
// ----------------------------------------------------------------------------
// Programmable phase sequencer. Steps a WIDTH-bit phase index from 0 up to a
// terminal value captured at start, either once (single-shot) or repeatedly
// (continuous). Feeds the 3:8 decoder stage: `phase` is the decoder select and
// `phase_valid` is the decoder enable.
//
// Build option:
//   PHASE_SEQ_ONEHOT_EN  defined   -> phase_oh is a registered one-hot of phase
//                        undefined -> phase_oh is tied to zero
//
// Parameters:
//   WIDTH        phase index width; one-hot width is 2**WIDTH
//
// Ports:
//   clk          in   rising-edge clock
//   clear        in   asynchronous active-low reset
//   start        in   begin a run (sampled in IDLE only)
//   stop         in   abort a run (sampled in RUN only)
//   mode         in   0 = single-shot, 1 = continuous (captured at start)
//   last         in   terminal phase index (captured at start)
//   phase        out  current phase index
//   phase_valid  out  phase is live (RUN)
//   busy         out  RUN or DONE
//   done         out  one-cycle pulse at end of run
//   wrap         out  one-cycle pulse on phase 0 after a continuous wrap
//   phase_oh     out  registered one-hot of phase, zero when not valid
// ============================================================================
module phase_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      last,
    output logic [WIDTH-1:0]      phase,
    output logic                  phase_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap,
    output logic [2**WIDTH-1:0]   phase_oh
);

    localparam int OH_W = 2 ** WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] last_q,  last_d;
    logic             mode_q,  mode_d;
    logic             wrap_q,  wrap_d;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        phase_d = phase_q;
        last_d  = last_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // start wins over a simultaneous stop; stop is not looked at here
                if (start) begin
                    state_d = S_RUN;
                    phase_d = '0;
                    last_d  = last;
                    mode_d  = mode;
                end
            end

            S_RUN: begin
                if (stop) begin
                    // abort: phase holds so the aborted position stays visible
                    state_d = S_DONE;
                end else if (phase_q == last_q) begin
                    if (!mode_q) begin
                        state_d = S_DONE;
                    end else begin
                        phase_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + WIDTH'(1);
                end
            end

            S_DONE: begin
                // start here is ignored; it must be presented again in IDLE
                state_d = S_IDLE;
                phase_d = '0;
            end

            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            last_q  <= '0;
            mode_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            phase_q <= phase_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
        end
    end

    // Status outputs are pure decodes of the state flop, so no input reaches
    // an output without passing through a register.
    assign phase       = phase_q;
    assign phase_valid = (state_q == S_RUN);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign wrap        = wrap_q;

    // ------------------------------------------------------------------------
    // Optional one-hot copy, loaded from the same next-state values as phase
    // so the two always change on the same edge.
    // ------------------------------------------------------------------------
`ifdef PHASE_SEQ_ONEHOT_EN
    localparam logic [OH_W-1:0] OH_ONE = OH_W'(1);

    logic [OH_W-1:0] phase_oh_q, phase_oh_d;

    always_comb begin
        phase_oh_d = '0;
        if (state_d == S_RUN) begin
            phase_oh_d = OH_ONE << phase_d;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            phase_oh_q <= '0;
        end else begin
            phase_oh_q <= phase_oh_d;
        end
    end

    assign phase_oh = phase_oh_q;
`else
    assign phase_oh = {OH_W{1'b0}};
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// tb_phase_sequencer
// ----------------------------------------------------------------------------
// Scoreboard bench for phase_sequencer (WIDTH = 3). The stimulus process
// drives inputs once per cycle and pushes the outputs it expects to see in
// that cycle; the monitor samples the DUT on every falling edge and compares
// against the oldest queued expectation. Cycles with nothing queued must show
// an idle DUT.
// ============================================================================
module tb_phase_sequencer;

    localparam int WIDTH = 3;
    localparam int OH_W  = 2 ** WIDTH;

    logic             clk = 1'b0;
    logic             clear;
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] phase;
    logic             phase_valid;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [OH_W-1:0]  phase_oh;

    phase_sequencer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .last        (last),
        .phase       (phase),
        .phase_valid (phase_valid),
        .busy        (busy),
        .done        (done),
        .wrap        (wrap),
        .phase_oh    (phase_oh)
    );

    always #5 clk = ~clk;

    // One expected cycle. pc: compare phase this cycle (phase is only
    // meaningful while valid, after a stop, and out of reset).
    typedef struct {
        string            name;
        logic             pc;
        logic [WIDTH-1:0] ph;
        logic             v;
        logic             d;
        logic             w;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic stim_done = 1'b0;

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin : monitor
        exp_t            e;
        logic [OH_W-1:0] exp_oh;
        logic            bad;
        while (!stim_done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                exp_oh = '0;
`ifdef PHASE_SEQ_ONEHOT_EN
                if (e.v) exp_oh[e.ph] = 1'b1;
`endif
                bad = (e.pc && (phase !== e.ph)) || (phase_valid !== e.v) ||
                      (done !== e.d) || (wrap !== e.w) ||
                      (busy !== (e.v | e.d)) || (phase_oh !== exp_oh);
                n_cmp++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s: got ph=%0d v=%b b=%b d=%b w=%b oh=%h, want ph=%0d(chk=%b) v=%b b=%b d=%b w=%b oh=%h",
                             e.name, phase, phase_valid, busy, done, wrap, phase_oh,
                             e.ph, e.pc, e.v, e.v | e.d, e.d, e.w, exp_oh);
                end
            end else if (phase_valid || busy || done || wrap) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_activity: got v=%b b=%b d=%b w=%b, want idle",
                         phase_valid, busy, done, wrap);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: got %0d unconsumed, want 0", exp_q.size());
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: push what this cycle should show, then advance.
    // ------------------------------------------------------------------------
    task automatic expect_cyc(input string nm, input logic pc, input logic [WIDTH-1:0] ph,
                              input logic v, input logic d, input logic w);
        exp_t e;
        e.name = nm; e.pc = pc; e.ph = ph; e.v = v; e.d = d; e.w = w;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_c(input string nm, input logic [WIDTH-1:0] ph, input logic w);
        expect_cyc(nm, 1'b1, ph, 1'b1, 1'b0, w);
    endtask

    task automatic done_c(input string nm, input logic pc, input logic [WIDTH-1:0] ph);
        expect_cyc(nm, pc, ph, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle_c(input string nm, input logic pc);
        expect_cyc(nm, pc, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin : stimulus
        clear = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; last = '0;
        #2 clear = 1'b0;
        @(posedge clk); #1;

        // Reset held with inputs toggling: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); stop = 1'($urandom); mode = 1'($urandom);
            last  = 3'($urandom);
            idle_c("reset_hold", 1'b1);
        end
        clear = 1'b1; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 5; i++) idle_c("reset_release", 1'b1);

        // Single-shot last=3; last changed mid-run must not matter.
        start = 1'b1; mode = 1'b0; last = 3'd3;
        idle_c("ss_start", 1'b1);
        start = 1'b0;
        run_c("ss_ph0", 3'd0, 1'b0);
        last = 3'd7;
        run_c("ss_ph1", 3'd1, 1'b0);
        run_c("ss_ph2", 3'd2, 1'b0);
        run_c("ss_ph3", 3'd3, 1'b0);
        done_c("ss_done", 1'b0, '0);
        idle_c("ss_idle", 1'b0);

        // Continuous last=2: wrap only on the 4th and 7th valid cycles.
        start = 1'b1; mode = 1'b1; last = 3'd2;
        idle_c("ct_start", 1'b0);
        start = 1'b0; mode = 1'b0;
        run_c("ct_c1", 3'd0, 1'b0);
        run_c("ct_c2", 3'd1, 1'b0);
        run_c("ct_c3", 3'd2, 1'b0);
        run_c("ct_c4", 3'd0, 1'b1);
        run_c("ct_c5", 3'd1, 1'b0);
        run_c("ct_c6", 3'd2, 1'b0);
        run_c("ct_c7", 3'd0, 1'b1);
        run_c("ct_c8", 3'd1, 1'b0);
        stop = 1'b1;  // stop at the terminal phase beats the wrap
        run_c("ct_c9", 3'd2, 1'b0);
        stop = 1'b0;
        done_c("ct_stop_done", 1'b1, 3'd2);
        idle_c("ct_idle", 1'b0);

        // Abort continuous last=7 at phase 4.
        start = 1'b1; mode = 1'b1; last = 3'd7;
        idle_c("ab_start", 1'b0);
        start = 1'b0;
        for (int i = 0; i < 4; i++) run_c("ab_run", 3'(i), 1'b0);
        stop = 1'b1;
        run_c("ab_ph4", 3'd4, 1'b0);
        stop = 1'b0;
        done_c("ab_done", 1'b1, 3'd4);
        idle_c("ab_idle", 1'b0);

        // last=0 single-shot: one valid cycle.
        start = 1'b1; mode = 1'b0; last = 3'd0;
        idle_c("z0_start", 1'b0);
        start = 1'b0;
        run_c("z0_ph0", 3'd0, 1'b0);
        done_c("z0_done", 1'b0, '0);
        idle_c("z0_idle", 1'b0);

        // last=0 continuous, started with stop also high (start wins).
        start = 1'b1; stop = 1'b1; mode = 1'b1; last = 3'd0;
        idle_c("z1_start", 1'b0);
        start = 1'b0; stop = 1'b0;
        run_c("z1_c1", 3'd0, 1'b0);
        run_c("z1_c2", 3'd0, 1'b1);
        stop = 1'b1;
        run_c("z1_c3", 3'd0, 1'b1);
        stop = 1'b0;
        done_c("z1_done", 1'b1, 3'd0);
        idle_c("z1_idle", 1'b0);

        // last=7 continuous: natural wrap 7->0; start held through DONE.
        start = 1'b1; mode = 1'b1; last = 3'd7;
        idle_c("w7_start", 1'b0);
        start = 1'b0;
        for (int i = 0; i < 8; i++) run_c("w7_run", 3'(i), 1'b0);
        run_c("w7_wrap", 3'd0, 1'b1);
        start = 1'b1; stop = 1'b1; mode = 1'b0; last = 3'd1;
        run_c("w7_stop", 3'd1, 1'b0);
        stop = 1'b0;
        done_c("w7_done_start_held", 1'b1, 3'd1);
        idle_c("w7_idle_start_held", 1'b0);
        start = 1'b0;
        run_c("rs_ph0", 3'd0, 1'b0);
        run_c("rs_ph1", 3'd1, 1'b0);
        done_c("rs_done", 1'b0, '0);
        idle_c("rs_idle", 1'b0);

        // Async reset at phase 5, between edges: zero before next edge, no done.
        start = 1'b1; mode = 1'b0; last = 3'd7;
        idle_c("ar_start", 1'b0);
        start = 1'b0;
        for (int i = 0; i < 5; i++) run_c("ar_run", 3'(i), 1'b0);
        clear = 1'b0;
        idle_c("ar_clear_now", 1'b1);
        idle_c("ar_clear_hold", 1'b1);
        clear = 1'b1;
        for (int i = 0; i < 3; i++) idle_c("ar_after", 1'b1);

        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
